// File: rtl/seq_shift_left_pkg.sv
// Shared definitions for the iterative left shifter: FSM encoding and default sizes.
package seq_shift_left_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SHW   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_left_1.sv
// Single-step combinational left shifter: one position per use, LSB filled from new_lsb.
module shift_left_1 #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] R,
  output logic             shifted_msb,
  input  logic [WIDTH-1:0] A,
  input  logic             new_lsb
);

  // Move everything up one bit; the old MSB falls out the top.
  always_comb begin
    R           = {A[WIDTH-2:0], new_lsb};
    shifted_msb = A[WIDTH-1];
  end

endmodule

// File: rtl/seq_shift_left.sv
// Iterative left shifter: loads an operand, then shifts one bit per clock
// with a latched fill bit until the captured count runs out.
module seq_shift_left
  import seq_shift_left_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   amt,
  input  logic             new_lsb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic             shifted_msb
);

  state_t           state, nxt;
  logic [SHW-1:0]   cnt;
  logic             fill;
  logic             accept;
  logic [WIDTH-1:0] step_r;
  logic             step_msb;

  // A new operation may begin from IDLE or straight out of DONE.
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  shift_left_1 #(.WIDTH(WIDTH)) u_step (
    .R           (step_r),
    .shifted_msb (step_msb),
    .A           (R),
    .new_lsb     (fill)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // Next-state and status outputs; busy and done are decoded from disjoint states.
  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) nxt = (amt == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (cnt == SHW'(1)) nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) nxt = (amt == '0) ? ST_DONE : ST_SHIFT;
        else       nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture on accept, register one shift step per SHIFT cycle,
  // otherwise hold so results stay visible after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R           <= '0;
      shifted_msb <= 1'b0;
      cnt         <= '0;
      fill        <= 1'b0;
    end else if (accept) begin
      R           <= A;
      shifted_msb <= 1'b0;
      cnt         <= amt;
      fill        <= new_lsb;
    end else if (state == ST_SHIFT) begin
      R           <= step_r;
      shifted_msb <= step_msb;
      cnt         <= cnt - SHW'(1);
    end
  end

endmodule

// File: tb/tb_seq_shift_left.sv
// Directed bench for seq_shift_left with hand-computed expected values.
module tb_seq_shift_left;
  import seq_shift_left_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [4:0]  amt = '0;
  logic        new_lsb = 1'b0;
  logic        busy, done, shifted_msb;
  logic [31:0] R;

  int n_chk = 0;
  int n_err = 0;

  seq_shift_left #(.WIDTH(32), .SHW(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .amt         (amt),
    .new_lsb     (new_lsb),
    .busy        (busy),
    .done        (done),
    .R           (R),
    .shifted_msb (shifted_msb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request (caller sits at a negedge), let one edge take it,
  // then scramble the inputs to show the captured copy is used.
  task automatic launch(input logic [31:0] a, input logic [4:0] n, input logic lsb);
    A = a; amt = n; new_lsb = lsb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; A = ~a; amt = ~n; new_lsb = ~lsb;
  endtask

  // Follow an accepted request: busy for n cycles, then done exactly once.
  task automatic watch(input string tag, input int n, input logic [31:0] er, input logic em);
    for (int i = 1; i <= n + 1; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 32'(busy), 32'(i <= n));
      chk({tag, "_done"}, 32'(done), 32'(i == n + 1));
    end
    chk({tag, "_R"}, R, er);
    chk({tag, "_msb"}, 32'(shifted_msb), 32'(em));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_R", R, 32'h0);
    chk("rst_msb", 32'(shifted_msb), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-bit shift
    @(negedge clk);
    launch(32'h8000_0001, 5'd1, 1'b0);
    watch("one", 1, 32'h0000_0002, 1'b1);
    @(negedge clk);
    chk("one_nodone", 32'(done), 32'h0);
    chk("one_hold_R", R, 32'h0000_0002);

    // Zero shift
    @(negedge clk);
    launch(32'h1234_5678, 5'd0, 1'b1);
    watch("zero", 0, 32'h1234_5678, 1'b0);

    // Maximum shift with 1 fill: A[1] is the last bit out, lower 31 bits all fill
    @(negedge clk);
    launch(32'h0000_0003, 5'd31, 1'b1);
    watch("max", 31, 32'hFFFF_FFFF, 1'b1);

    // Start while busy is ignored
    @(negedge clk);
    launch(32'h0000_00F0, 5'd4, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("ign_busy", 32'(busy), 32'(i <= 4));
      chk("ign_done", 32'(done), 32'(i == 5));
      if (i == 5) begin
        chk("ign_R", R, 32'h0000_0F00);
        chk("ign_msb", 32'(shifted_msb), 32'h0);
      end
      if (i == 2) begin
        A = 32'hFFFF_FFFF; amt = 5'd0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end

    // Back-to-back: second request issued in the DONE cycle. Bit 30 of the
    // second operand is the final bit pushed out of the MSB.
    @(negedge clk);
    launch(32'h0000_0011, 5'd1, 1'b1);
    watch("b2b_a", 1, 32'h0000_0023, 1'b0);
    launch(32'h4000_0000, 5'd2, 1'b0);
    watch("b2b_b", 2, 32'h0000_0000, 1'b1);
    @(negedge clk);
    chk("b2b_nodone", 32'(done), 32'h0);

    // Reset mid-operation, with start held high across release
    @(negedge clk);
    launch(32'hABCD_EF01, 5'd10, 1'b1);
    repeat (4) @(negedge clk);
    chk("mid_busy_pre", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_R", R, 32'h0);
    chk("mid_rst_msb", 32'(shifted_msb), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    chk("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    A = 32'h0000_000F; amt = 5'd3; new_lsb = 1'b1; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    launch(32'h0000_000F, 5'd3, 1'b1);
    watch("post_rst", 3, 32'h0000_007F, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
